// File: rtl/uart_host_sequencer.sv
// Host-side UART transaction engine for the MIPS debug link: command byte, LSB-first
// payload, response capture, optional READY_CHAR handshake, with a per-phase idle timeout.
module uart_host_sequencer #(
  parameter int          MAX_TX_BYTES   = 4,
  parameter int          MAX_RX_BYTES   = 17,
  parameter logic [7:0]  READY_CHAR     = 8'h52,
  parameter int          TIMEOUT_CYCLES = 2000000,
  parameter int          TXL_W          = $clog2(MAX_TX_BYTES + 1),
  parameter int          RXL_W          = $clog2(MAX_RX_BYTES + 1)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic [7:0]                i_cmd,
  input  logic [8*MAX_TX_BYTES-1:0] i_payload,
  input  logic [TXL_W-1:0]          i_tx_len,
  input  logic [RXL_W-1:0]          i_rx_len,
  input  logic                      i_wait_ready,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_timeout,
  output logic [8*MAX_RX_BYTES-1:0] o_rx_data,
  output logic [RXL_W-1:0]          o_rx_count,
  output logic                      o_tx_start,
  output logic [7:0]                o_tx_data,
  input  logic                      i_tx_done,
  input  logic                      i_rx_valid,
  input  logic [7:0]                i_rx_data
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TXL_W-1:0] TX_MAX   = TXL_W'(MAX_TX_BYTES);
  localparam logic [RXL_W-1:0] RX_MAX   = RXL_W'(MAX_RX_BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_TX_CMD, S_TX_WAIT, S_TX_PAY, S_RECV, S_WAIT_RDY, S_DONE
  } state_t;

  state_t                    r_state, w_next;
  logic [8*MAX_TX_BYTES-1:0] r_payload;
  logic [TXL_W-1:0]          r_tx_len, r_idx;
  logic [RXL_W-1:0]          r_rx_len, r_rx_count;
  logic                      r_wait_rdy, r_timeout;
  logic [7:0]                r_tx_data;
  logic [8*MAX_RX_BYTES-1:0] r_rx_data;
  logic [TMO_W-1:0]          r_tmo_cnt;

  logic       w_accept, w_waiting, w_event, w_tmo_abort;
  logic       w_pay_more, w_rx_take, w_rx_last, w_rdy_hit;
  logic [7:0] w_pay_byte;

  assign w_accept   = (r_state == S_IDLE) && i_start;
  assign w_pay_more = r_idx < r_tx_len;
  assign w_rx_take  = (r_state == S_RECV) && i_rx_valid;
  assign w_rx_last  = w_rx_take && ((r_rx_count + RXL_W'(1)) == r_rx_len);
  assign w_rdy_hit  = (r_state == S_WAIT_RDY) && i_rx_valid && (i_rx_data == READY_CHAR);
  assign w_waiting  = (r_state == S_TX_WAIT) || (r_state == S_RECV) || (r_state == S_WAIT_RDY);
  // A completion event in the expiry cycle wins over the timeout.
  assign w_event    = ((r_state == S_TX_WAIT) && i_tx_done) ||
                      (((r_state == S_RECV) || (r_state == S_WAIT_RDY)) && i_rx_valid);
  assign w_tmo_abort = w_waiting && !w_event && (r_tmo_cnt == TMO_LAST);

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_pay_byte = 8'h00;
    for (int k = 0; k < MAX_TX_BYTES; k++)
      if (r_idx == TXL_W'(k)) w_pay_byte = r_payload[8*k +: 8];
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (i_start) w_next = S_TX_CMD;
      S_TX_CMD:  w_next = S_TX_WAIT;
      S_TX_WAIT: begin
        if (i_tx_done) begin
          if (w_pay_more)             w_next = S_TX_PAY;
          else if (r_rx_len != '0)    w_next = S_RECV;
          else if (r_wait_rdy)        w_next = S_WAIT_RDY;
          else                        w_next = S_DONE;
        end else if (w_tmo_abort)     w_next = S_DONE;
      end
      S_TX_PAY:  w_next = S_TX_WAIT;
      S_RECV: begin
        if (w_rx_last)                w_next = r_wait_rdy ? S_WAIT_RDY : S_DONE;
        else if (w_tmo_abort)         w_next = S_DONE;
      end
      S_WAIT_RDY: if (w_rdy_hit || w_tmo_abort) w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy     = 1'b0;
    o_done     = 1'b0;
    o_tx_start = 1'b0;
    unique case (r_state)
      S_TX_CMD, S_TX_PAY: begin o_busy = 1'b1; o_tx_start = 1'b1; end
      S_TX_WAIT, S_RECV, S_WAIT_RDY: o_busy = 1'b1;
      S_DONE:  o_done = 1'b1;
      default: ;
    endcase
  end

  // Idle counter restarts on every state change and every accepted handshake.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                              r_tmo_cnt <= '0;
    else if ((w_next != r_state) || w_event) r_tmo_cnt <= '0;
    else if (w_waiting)                     r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
  end

  // NOTE: the response buffer is reset too, since it is a visible output that must read 0 after reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_payload  <= '0;
      r_tx_len   <= '0;
      r_rx_len   <= '0;
      r_wait_rdy <= 1'b0;
      r_idx      <= '0;
      r_tx_data  <= 8'h00;
      r_rx_data  <= '0;
      r_rx_count <= '0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_tx_data  <= i_cmd;
        r_payload  <= i_payload;
        r_tx_len   <= (i_tx_len > TX_MAX) ? TX_MAX : i_tx_len;
        r_rx_len   <= (i_rx_len > RX_MAX) ? RX_MAX : i_rx_len;
        r_wait_rdy <= i_wait_ready;
        r_idx      <= '0;
        r_rx_data  <= '0;
        r_rx_count <= '0;
        r_timeout  <= 1'b0;
      end
      if ((r_state == S_TX_WAIT) && i_tx_done && w_pay_more) begin
        r_tx_data <= w_pay_byte;
        r_idx     <= r_idx + TXL_W'(1);
      end
      if (w_rx_take && (r_rx_count < RX_MAX)) begin
        for (int k = 0; k < MAX_RX_BYTES; k++)
          if (r_rx_count == RXL_W'(k)) r_rx_data[8*k +: 8] <= i_rx_data;
        r_rx_count <= r_rx_count + RXL_W'(1);
      end
      if (w_tmo_abort) r_timeout <= 1'b1;
    end
  end

  assign o_timeout  = r_timeout;
  assign o_rx_data  = r_rx_data;
  assign o_rx_count = r_rx_count;
  assign o_tx_data  = r_tx_data;

endmodule
